// File: rtl/cnn_window_gen_if.sv
// Pixel stream in, packed convolution window out.
// The window generator itself uses the slave side.
interface cnn_window_gen_if #(
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int I_F_BW = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
);
    localparam int CW = ($clog2(IMG_W) < 1) ? 1 : $clog2(IMG_W);
    localparam int RW = ($clog2(IMG_H) < 1) ? 1 : $clog2(IMG_H);

    logic                       i_in_valid;
    logic [I_F_BW-1:0]          i_in_pixel;
    logic                       o_ot_valid;
    logic [KX*KY*I_F_BW-1:0]    o_ot_fmap;
    logic [CW-1:0]              o_ot_x;
    logic [RW-1:0]              o_ot_y;
    logic                       o_ot_frame_done;

    modport master (
        output i_in_valid, i_in_pixel,
        input  o_ot_valid, o_ot_fmap, o_ot_x, o_ot_y, o_ot_frame_done
    );

    modport slave (
        input  i_in_valid, i_in_pixel,
        output o_ot_valid, o_ot_fmap, o_ot_x, o_ot_y, o_ot_frame_done
    );
endinterface

// File: rtl/cnn_window_gen.sv
// Streaming KY x KX sliding-window generator for the CNN kernel.
// Line-buffer delay chain plus a window register array; no padding.
module cnn_window_gen #(
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int I_F_BW = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic            clk,
    input  logic            reset,
    cnn_window_gen_if.slave bus
);
    localparam int CW = ($clog2(IMG_W) < 1) ? 1 : $clog2(IMG_W);
    localparam int RW = ($clog2(IMG_H) < 1) ? 1 : $clog2(IMG_H);
    localparam int FW = KX * KY * I_F_BW;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KY - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [I_F_BW-1:0] lb      [KY-1][IMG_W];
    logic [I_F_BW-1:0] win     [KY][KX];
    logic [I_F_BW-1:0] win_nxt [KY][KX];
    logic [FW-1:0]     fmap_nxt;
    logic              accept;
    logic              col_end;
    logic              row_end;
    logic              fits;

    assign accept  = bus.i_in_valid;
    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);
    assign fits    = (row >= ROW_K) && (col >= COL_K);

    // Rightmost column: oldest line buffer on top, live pixel at the bottom.
    always_comb begin
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                win_nxt[ky][kx] = '0;
            end
        end
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
                win_nxt[ky][kx] = win[ky][kx+1];
            end
        end
        for (int ky = 0; ky < KY - 1; ky++) begin
            win_nxt[ky][KX-1] = lb[KY-2-ky][col];
        end
        win_nxt[KY-1][KX-1] = bus.i_in_pixel;
    end

    always_comb begin
        fmap_nxt = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                fmap_nxt[(ky*KX+kx)*I_F_BW +: I_F_BW] = win_nxt[ky][kx];
            end
        end
    end

    // Storage only; stale contents are flushed before row KY-1 of any frame.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            lb[0][col] <= bus.i_in_pixel;
            for (int k = 1; k < KY - 1; k++) begin
                lb[k][col] <= lb[k-1][col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col                 <= '0;
            row                 <= '0;
            bus.o_ot_valid      <= 1'b0;
            bus.o_ot_fmap       <= '0;
            bus.o_ot_x          <= '0;
            bus.o_ot_y          <= '0;
            bus.o_ot_frame_done <= 1'b0;
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
        end else begin
            bus.o_ot_valid      <= accept && fits;
            bus.o_ot_frame_done <= accept && col_end && row_end;
            if (accept) begin
                win <= win_nxt;
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) begin
                    row <= row_end ? '0 : row + 1'b1;
                end
                if (fits) begin
                    bus.o_ot_fmap <= fmap_nxt;
                    bus.o_ot_x    <= col - COL_K;
                    bus.o_ot_y    <= row - ROW_K;
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: scoreboard of expected windows
// built from an image model, two parameter sets.
module tb_cnn_window_gen;
    typedef struct packed {
        logic [4:0]   x;
        logic [4:0]   y;
        logic         done;
        logic [199:0] fmap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cnn_window_gen_if bus ();
    cnn_window_gen_if #(.KX(3), .KY(3), .IMG_W(8), .IMG_H(6)) bus3 ();

    cnn_window_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cnn_window_gen #(.KX(3), .KY(3), .IMG_W(8), .IMG_H(6)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    exp_t q5[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;
    int   idx = 0;
    int   last_idx = -1;

    int           wins5 = 0, done5 = 0, cap5 = 0, cap_idx5 = -1;
    logic [199:0] cap_fmap5, last_fmap5;
    logic [4:0]   cap_x5, cap_y5, last_x5, last_y5;
    logic         last_done5;
    int           wins3 = 0, done3 = 0, cap_idx3 = -1;
    logic [4:0]   last_x3, last_y3;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] exp_fmap(input int k, input int w,
                                              input int r, input int c,
                                              input int off);
        logic [199:0] f;
        f = '0;
        for (int ky = 0; ky < k; ky++) begin
            for (int kx = 0; kx < k; kx++) begin
                f[(ky*k+kx)*8 +: 8] =
                    8'((((r - (k-1) + ky) * w) + (c - (k-1) + kx) + off) % 256);
            end
        end
        return f;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_ot_valid === 1'b1) begin
            chk("win5_expected", 256'(q5.size() > 0), 256'(1));
            if (q5.size() > 0) begin
                e = q5.pop_front();
                chk("win5_x", 256'(bus.o_ot_x), 256'(e.x));
                chk("win5_y", 256'(bus.o_ot_y), 256'(e.y));
                chk("win5_done", 256'(bus.o_ot_frame_done), 256'(e.done));
                chk("win5_fmap", 256'(bus.o_ot_fmap), 256'(e.fmap));
            end
            if (wins5 == cap5) begin
                cap_idx5  = last_idx;
                cap_fmap5 = bus.o_ot_fmap;
                cap_x5    = bus.o_ot_x;
                cap_y5    = bus.o_ot_y;
            end
            last_fmap5 = bus.o_ot_fmap;
            last_x5    = bus.o_ot_x;
            last_y5    = bus.o_ot_y;
            last_done5 = bus.o_ot_frame_done;
            wins5++;
            if (bus.o_ot_frame_done === 1'b1) done5++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus3.o_ot_valid === 1'b1) begin
            chk("win3_expected", 256'(q3.size() > 0), 256'(1));
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("win3_x", 256'(bus3.o_ot_x), 256'(e.x));
                chk("win3_y", 256'(bus3.o_ot_y), 256'(e.y));
                chk("win3_done", 256'(bus3.o_ot_frame_done), 256'(e.done));
                chk("win3_fmap", 256'(bus3.o_ot_fmap), 256'(e.fmap));
            end
            if (wins3 == 0) cap_idx3 = last_idx;
            last_x3 = 5'(bus3.o_ot_x);
            last_y3 = 5'(bus3.o_ot_y);
            wins3++;
            if (bus3.o_ot_frame_done === 1'b1) done3++;
        end
    end

    task automatic run_frame(input int k, input int w, input int h,
                             input int off, input int duty, input int limit);
        int   n;
        exp_t e;
        logic [7:0] v;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n == limit) return;
                while (duty < 100 && $urandom_range(0, 99) >= duty) begin
                    @(posedge clk);
                    #1;
                end
                v      = 8'((r * w + c + off) % 256);
                e.x    = 5'(c - (k - 1));
                e.y    = 5'(r - (k - 1));
                e.done = (r == h - 1) && (c == w - 1);
                e.fmap = '0;
                if (r >= k - 1 && c >= k - 1) e.fmap = exp_fmap(k, w, r, c, off);
                if (k == 3) begin
                    bus3.i_in_valid = 1'b1;
                    bus3.i_in_pixel = v;
                    if (r >= 2 && c >= 2) q3.push_back(e);
                end else begin
                    bus.i_in_valid = 1'b1;
                    bus.i_in_pixel = v;
                    if (r >= 4 && c >= 4) q5.push_back(e);
                end
                @(posedge clk);
                #1;
                last_idx = idx;
                idx++;
                n++;
                bus.i_in_valid  = 1'b0;
                bus3.i_in_valid = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        wins5 = 0; done5 = 0; cap5 = 0; cap_idx5 = -1;
        wins3 = 0; done3 = 0; cap_idx3 = -1;
        idx = 0; last_idx = -1;
    endtask

    initial begin
        bus.i_in_valid  = 1'b0;
        bus.i_in_pixel  = '0;
        bus3.i_in_valid = 1'b0;
        bus3.i_in_pixel = '0;

        // Reset state
        reset = 1'b1;
        idle(3);
        chk("rst_valid", 256'(bus.o_ot_valid), 256'(0));
        chk("rst_fmap", 256'(bus.o_ot_fmap), 256'(0));
        chk("rst_x", 256'(bus.o_ot_x), 256'(0));
        chk("rst_y", 256'(bus.o_ot_y), 256'(0));
        chk("rst_done", 256'(bus.o_ot_frame_done), 256'(0));
        chk("rst3_valid", 256'(bus3.o_ot_valid), 256'(0));
        reset = 1'b0;
        idle(1);

        // Continuous frame
        clear_stats();
        run_frame(5, 28, 28, 0, 100, -1);
        idle(3);
        chk("c_wins", 256'(wins5), 256'(576));
        chk("c_done", 256'(done5), 256'(1));
        chk("c_first_idx", 256'(cap_idx5), 256'(116));
        chk("c_first_e0", 256'(cap_fmap5[0 +: 8]), 256'(0));
        chk("c_first_e4", 256'(cap_fmap5[32 +: 8]), 256'(4));
        chk("c_first_e5", 256'(cap_fmap5[40 +: 8]), 256'(28));
        chk("c_first_e24", 256'(cap_fmap5[192 +: 8]), 256'(116));
        chk("c_first_x", 256'(cap_x5), 256'(0));
        chk("c_first_y", 256'(cap_y5), 256'(0));
        chk("c_last_x", 256'(last_x5), 256'(23));
        chk("c_last_y", 256'(last_y5), 256'(23));
        chk("c_last_e0", 256'(last_fmap5[0 +: 8]), 256'(155));
        chk("c_last_e24", 256'(last_fmap5[192 +: 8]), 256'(15));
        chk("c_last_done", 256'(last_done5), 256'(1));
        chk("c_q_empty", 256'(q5.size()), 256'(0));
        chk("c_hold_fmap", 256'(bus.o_ot_fmap), 256'(last_fmap5));
        chk("c_idle_valid", 256'(bus.o_ot_valid), 256'(0));

        // Gapped input, ~40% duty
        clear_stats();
        run_frame(5, 28, 28, 0, 40, -1);
        idle(3);
        chk("g_wins", 256'(wins5), 256'(576));
        chk("g_done", 256'(done5), 256'(1));
        chk("g_first_idx", 256'(cap_idx5), 256'(116));
        chk("g_q_empty", 256'(q5.size()), 256'(0));

        // Back-to-back frames, second offset by 100
        clear_stats();
        cap5 = 576;
        run_frame(5, 28, 28, 0, 100, -1);
        run_frame(5, 28, 28, 100, 100, -1);
        idle(3);
        chk("b_wins", 256'(wins5), 256'(1152));
        chk("b_done", 256'(done5), 256'(2));
        chk("b_f2_first_idx", 256'(cap_idx5), 256'(900));
        chk("b_f2_e0", 256'(cap_fmap5[0 +: 8]), 256'(100));
        chk("b_f2_e24", 256'(cap_fmap5[192 +: 8]), 256'(216));
        chk("b_f2_x", 256'(cap_x5), 256'(0));
        chk("b_f2_y", 256'(cap_y5), 256'(0));
        chk("b_q_empty", 256'(q5.size()), 256'(0));

        // Reset after 300 pixels, pixel during reset is dropped
        clear_stats();
        run_frame(5, 28, 28, 0, 100, 300);
        reset = 1'b1;
        bus.i_in_valid = 1'b1;
        bus.i_in_pixel = 8'hAA;
        idle(1);
        bus.i_in_valid = 1'b0;
        reset = 1'b0;
        chk("m_rst_valid", 256'(bus.o_ot_valid), 256'(0));
        chk("m_rst_fmap", 256'(bus.o_ot_fmap), 256'(0));
        chk("m_q_empty0", 256'(q5.size()), 256'(0));
        idle(1);
        clear_stats();
        run_frame(5, 28, 28, 0, 100, -1);
        idle(3);
        chk("m_wins", 256'(wins5), 256'(576));
        chk("m_done", 256'(done5), 256'(1));
        chk("m_first_idx", 256'(cap_idx5), 256'(116));
        chk("m_q_empty", 256'(q5.size()), 256'(0));

        // 3x3 kernel, 8x6 image
        clear_stats();
        run_frame(3, 8, 6, 0, 100, -1);
        idle(3);
        chk("s_wins", 256'(wins3), 256'(24));
        chk("s_done", 256'(done3), 256'(1));
        chk("s_first_idx", 256'(cap_idx3), 256'(18));
        chk("s_last_x", 256'(last_x3), 256'(5));
        chk("s_last_y", 256'(last_y3), 256'(3));
        chk("s_q_empty", 256'(q3.size()), 256'(0));
        chk("s_big_quiet", 256'(wins5), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
